// File: rtl/sam_stream_tx.sv
// sam_stream_tx -- serial stream generator for the SAM encoder str/mode inputs.
//
// A transfer consists of a configuration phase (mode=1) that sends the key
// length n, the key d and the mask N MSB first, followed by a normal phase
// (mode=0) with LEAD idle cycles, one pulse-width symbol per message bit and
// a single-cycle terminator pulse so the receiver finalises the last bit.
//
// Optional build macro: SAM_TX_ABORT_EN adds the `abort` input, which cancels
// a running transfer without sending the terminator.
//
// Ports:
//   clk        clock, all outputs registered on posedge
//   reset      asynchronous active-low reset
//   abort      (SAM_TX_ABORT_EN only) cancel a running transfer
//   start      one-cycle request, sampled only in IDLE
//   n_in       log2 message length, legal 0..4
//   d_in       d key, bits [2^n-1:0] used
//   capsn_in   N mask, bits [2^n-1:0] used
//   msg_in     plaintext, bits [2^n-1:0] used
//   str        serial data line
//   mode       1 = configuration phase, 0 = idle / normal phase
//   busy       high from start acceptance until done
//   done       one-cycle pulse after the terminator
//   err        one-cycle pulse when start is rejected (n_in > 4)
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start
// S_CFG_N  | sending n[3:0], run counter holds remaining cycles - 1
// S_CFG_D  | sending d[L-1:0], bit counter holds the index on the line
// S_CFG_CN | sending N[L-1:0], bit counter holds the index on the line
// S_LEAD   | low gap between config and first symbol
// S_SYM_HI | high run of the symbol for msg[bit]
// S_SYM_LO | low run of the symbol for msg[bit]
// S_TERM   | terminator high cycle

module sam_stream_tx #(
  parameter int SYM_LONG  = 12,
  parameter int SYM_SHORT = 6,
  parameter int LEAD      = 1
) (
  input  logic        clk,
  input  logic        reset,
`ifdef SAM_TX_ABORT_EN
  input  logic        abort,
`endif
  input  logic        start,
  input  logic [3:0]  n_in,
  input  logic [15:0] d_in,
  input  logic [15:0] capsn_in,
  input  logic [15:0] msg_in,
  output logic        str,
  output logic        mode,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [5:0] LONG_M1  = 6'(SYM_LONG - 1);
  localparam logic [5:0] SHORT_M1 = 6'(SYM_SHORT - 1);
  localparam logic [5:0] LEAD_M1  = 6'(LEAD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG_N,
    S_CFG_D,
    S_CFG_CN,
    S_LEAD,
    S_SYM_HI,
    S_SYM_LO,
    S_TERM
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic        str_d, mode_d, busy_d, done_d, err_d;

  logic [3:0]  n_sh;
  logic [15:0] d_sh;
  logic [15:0] capsn_sh;
  logic [15:0] msg_sh;

  logic        abort_req;
  logic        accept;
  logic [4:0]  len_m1;
  logic [3:0]  bit_dec;
  logic [1:0]  n_idx;

`ifdef SAM_TX_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // abort also blocks a start presented in the same cycle
  assign accept  = (state_q == S_IDLE) && start && !abort_req && (n_in <= 4'd4);
  assign len_m1  = 5'((5'd1 << n_sh) - 5'd1);
  assign bit_dec = bit_q[3:0] - 4'd1;
  assign n_idx   = cnt_q[1:0] - 2'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      str      <= 1'b0;
      mode     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      n_sh     <= '0;
      d_sh     <= '0;
      capsn_sh <= '0;
      msg_sh   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      str     <= str_d;
      mode    <= mode_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
      if (accept) begin
        n_sh     <= n_in;
        d_sh     <= d_in;
        capsn_sh <= capsn_in;
        msg_sh   <= msg_in;
      end
    end
  end

  // Next-state logic computes the line values for the cycle being entered,
  // so str/mode/busy change on the same edge as the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    str_d   = 1'b0;
    mode_d  = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start && !abort_req) begin
          if (n_in > 4'd4) begin
            err_d = 1'b1;
          end else begin
            state_d = S_CFG_N;
            cnt_d   = 6'd3;
            str_d   = n_in[3];
            mode_d  = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end

      S_CFG_N: begin
        mode_d = 1'b1;
        if (cnt_q == 6'd0) begin
          state_d = S_CFG_D;
          bit_d   = len_m1;
          str_d   = d_sh[len_m1[3:0]];
        end else begin
          cnt_d = cnt_q - 6'd1;
          str_d = n_sh[n_idx];
        end
      end

      S_CFG_D: begin
        mode_d = 1'b1;
        if (bit_q == 5'd0) begin
          state_d = S_CFG_CN;
          bit_d   = len_m1;
          str_d   = capsn_sh[len_m1[3:0]];
        end else begin
          bit_d = bit_q - 5'd1;
          str_d = d_sh[bit_dec];
        end
      end

      S_CFG_CN: begin
        if (bit_q == 5'd0) begin
          // mode drops on the edge after the last N bit
          state_d = S_LEAD;
          cnt_d   = LEAD_M1;
        end else begin
          mode_d = 1'b1;
          bit_d  = bit_q - 5'd1;
          str_d  = capsn_sh[bit_dec];
        end
      end

      S_LEAD: begin
        if (cnt_q == 6'd0) begin
          state_d = S_SYM_HI;
          bit_d   = len_m1;
          cnt_d   = msg_sh[len_m1[3:0]] ? LONG_M1 : SHORT_M1;
          str_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end

      S_SYM_HI: begin
        if (cnt_q == 6'd0) begin
          state_d = S_SYM_LO;
          cnt_d   = msg_sh[bit_q[3:0]] ? SHORT_M1 : LONG_M1;
        end else begin
          cnt_d = cnt_q - 6'd1;
          str_d = 1'b1;
        end
      end

      S_SYM_LO: begin
        if (cnt_q == 6'd0) begin
          str_d = 1'b1;
          if (bit_q == 5'd0) begin
            state_d = S_TERM;
          end else begin
            state_d = S_SYM_HI;
            bit_d   = bit_q - 5'd1;
            cnt_d   = msg_sh[bit_dec] ? LONG_M1 : SHORT_M1;
          end
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end

      S_TERM: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        cnt_d   = 6'd0;
        bit_d   = 5'd0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (abort_req && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = 6'd0;
      bit_d   = 5'd0;
      str_d   = 1'b0;
      mode_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

endmodule

// File: tb/tb_sam_stream_tx.sv
module tb_sam_stream_tx;

  localparam int SYM_LONG  = 12;
  localparam int SYM_SHORT = 6;
  localparam int LEAD      = 1;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  n_in;
  logic [15:0] d_in;
  logic [15:0] capsn_in;
  logic [15:0] msg_in;
  logic        str;
  logic        mode;
  logic        busy;
  logic        done;
  logic        err;
`ifdef SAM_TX_ABORT_EN
  logic        abort;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int exp_done_cnt = 0;

  bit exp_str[$];
  bit exp_mode[$];

  sam_stream_tx #(
    .SYM_LONG (SYM_LONG),
    .SYM_SHORT(SYM_SHORT),
    .LEAD     (LEAD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
`ifdef SAM_TX_ABORT_EN
    .abort   (abort),
`endif
    .start   (start),
    .n_in    (n_in),
    .d_in    (d_in),
    .capsn_in(capsn_in),
    .msg_in  (msg_in),
    .str     (str),
    .mode    (mode),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt++;

  task automatic check1(input string tag, input logic obs, input logic exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  // Expected line waveform for one transfer, one entry per busy cycle.
  function automatic void build_model(input logic [3:0] n, input logic [15:0] d,
                                      input logic [15:0] cn, input logic [15:0] msg);
    int len;
    int hi;
    len = 1 << n;
    exp_str.delete();
    exp_mode.delete();
    for (int i = 3; i >= 0; i--) begin exp_str.push_back(n[i]); exp_mode.push_back(1'b1); end
    for (int i = len - 1; i >= 0; i--) begin exp_str.push_back(d[i]); exp_mode.push_back(1'b1); end
    for (int i = len - 1; i >= 0; i--) begin exp_str.push_back(cn[i]); exp_mode.push_back(1'b1); end
    for (int i = 0; i < LEAD; i++) begin exp_str.push_back(1'b0); exp_mode.push_back(1'b0); end
    for (int i = len - 1; i >= 0; i--) begin
      hi = msg[i] ? SYM_LONG : SYM_SHORT;
      for (int k = 0; k < SYM_LONG + SYM_SHORT; k++) begin
        exp_str.push_back(k < hi);
        exp_mode.push_back(1'b0);
      end
    end
    exp_str.push_back(1'b1);
    exp_mode.push_back(1'b0);
  endfunction

  // Runs one transfer and checks every busy cycle. With disturb set, inputs
  // are scrambled and start is re-pulsed while busy and on the terminator cycle.
  task automatic run_xfer(input logic [3:0] n, input logic [15:0] d, input logic [15:0] cn,
                          input logic [15:0] msg, input bit disturb);
    int sz;
    build_model(n, d, cn, msg);
    sz = exp_str.size();
    checki("model_len", sz, 4 + 2 * (1 << n) + LEAD + (1 << n) * (SYM_LONG + SYM_SHORT) + 1);
    n_in = n; d_in = d; capsn_in = cn; msg_in = msg; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < sz; k++) begin
      check1("str", str, exp_str[k]);
      check1("mode", mode, exp_mode[k]);
      check1("busy", busy, 1'b1);
      check1("done_early", done, 1'b0);
      if (disturb && (k == 5 || k == 20)) begin
        start = 1'b1;
        n_in = 4'($urandom_range(0, 4));
        d_in = 16'($urandom);
        capsn_in = 16'($urandom);
        msg_in = 16'($urandom);
      end else if (disturb && k == sz - 1) begin
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    exp_done_cnt++;
    check1("done", done, 1'b1);
    check1("busy_end", busy, 1'b0);
    check1("str_end", str, 1'b0);
    check1("mode_end", mode, 1'b0);
    @(negedge clk);
    check1("done_pulse", done, 1'b0);
    check1("busy_after", busy, 1'b0);
    check1("err_after", err, 1'b0);
    check1("mode_after", mode, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    n_in = '0; d_in = '0; capsn_in = '0; msg_in = '0;
`ifdef SAM_TX_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check1("rst_str", str, 1'b0);
    check1("rst_mode", mode, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_err", err, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // nominal transfer with mid-transfer disturbance
    run_xfer(4'd2, 16'h000A, 16'h0001, 16'h0006, 1'b1);
    // shortest and longest messages
    run_xfer(4'd0, 16'h0000, 16'h0000, 16'h0001, 1'b0);
    run_xfer(4'd4, 16'hFFFF, 16'h0000, 16'hA5C3, 1'b0);

    // illegal length rejected
    n_in = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check1("err_pulse", err, 1'b1);
    check1("err_busy", busy, 1'b0);
    check1("err_mode", mode, 1'b0);
    check1("err_str", str, 1'b0);
    @(negedge clk);
    check1("err_once", err, 1'b0);
    check1("err_idle_busy", busy, 1'b0);
    run_xfer(4'd1, 16'h0002, 16'h0001, 16'h0001, 1'b0);

    // async reset in CFG_D
    n_in = 4'd3; d_in = 16'h00FF; capsn_in = 16'h0000; msg_in = 16'h0055; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check1("cfgd_mode", mode, 1'b1);
    check1("cfgd_str", str, 1'b1);
    reset = 1'b0;
    #1;
    check1("arst_str", str, 1'b0);
    check1("arst_mode", mode, 1'b0);
    check1("arst_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_xfer(4'd1, 16'h0001, 16'h0003, 16'h0002, 1'b1);

`ifdef SAM_TX_ABORT_EN
    build_model(4'd2, 16'h0005, 16'h0003, 16'h0009);
    n_in = 4'd2; d_in = 16'h0005; capsn_in = 16'h0003; msg_in = 16'h0009; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    check1("abt_busy_pre", busy, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check1("abt_mode", mode, 1'b0);
    check1("abt_str", str, 1'b0);
    check1("abt_busy", busy, 1'b0);
    check1("abt_done", done, 1'b0);
    repeat (5) @(negedge clk);
    check1("abt_idle_done", done, 1'b0);
    checki("abt_done_cnt", done_cnt, exp_done_cnt);
`endif

    // randomized transfers
    for (int t = 0; t < 6; t++) begin
      run_xfer(4'($urandom_range(0, 4)), 16'($urandom), 16'($urandom), 16'($urandom),
               bit'($urandom_range(0, 1)));
    end

    checki("done_count", done_cnt, exp_done_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sam_stream_tx.md
Name: sam_stream_tx

Overview:
- Serial stream generator feeding the SAM encoder's `str`/`mode` inputs.
- It drives the configuration phase: key length n, key d and mask N, all with `mode` high.
- It then drives the normal phase with `mode` low: a message of 2^n bits, each sent as a pulse-width symbol (run of ones followed by a run of zeros).
- It closes with a terminator rising edge so the receiver finalises the last bit and raises its `valid`.

Parameters:
- SYM_LONG, 12, cycles of the dominant level within a symbol.
- SYM_SHORT, 6, cycles of the minor level within a symbol. SYM_LONG+SYM_SHORT must lie in 10..60; SYM_LONG>SYM_SHORT>0.
- LEAD, 1, low cycles between config end and first symbol (>=1).

Ports:
- clk  input  1  clock; all outputs registered on posedge.
- reset  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- n_in  input  4  log2 message length; legal 0..4.
- d_in  input  16  d key; bits [2^n-1:0] used.
- capsn_in  input  16  N mask; bits [2^n-1:0] used.
- msg_in  input  16  plaintext; bits [2^n-1:0] used.
- str  output  1  serial data line.
- mode  output  1  1 = config phase, 0 = idle/normal.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse after terminator.
- err  output  1  one-cycle pulse: start rejected because n_in>4.

Behaviour:
- Reset values: str=0, mode=0, busy=0, done=0, err=0, state=IDLE, all counters and shadow regs 0.
- Accepting start in IDLE:
  - n_in, d_in, capsn_in and msg_in are latched into shadow registers; later input changes are ignored.
  - L = 1<<n (1..16).
  - If n_in>4: err=1 for one cycle, stay IDLE, mode and str stay 0.
- States: IDLE, CFG_N, CFG_D, CFG_CN, LEAD, SYM_HI, SYM_LO, TERM.
- CFG_N (4 cycles):
  - mode=1, driven on the same edge as the first bit.
  - str=n[3],n[2],n[1],n[0], MSB first.
- CFG_D (L cycles): mode=1, str=d[L-1] down to d[0].
- CFG_CN (L cycles): mode=1, str=N[L-1] down to N[0].
- Config timing:
  - mode is high for exactly 4+2L consecutive cycles.
  - mode falls on the edge after the last N bit.
- LEAD: mode=0, str=0 for LEAD cycles.
- Symbol per bit, bit index i from L-1 down to 0, msg[i]:
  - SYM_HI: str=1 for SYM_LONG cycles if msg[i]=1, else SYM_SHORT cycles.
  - SYM_LO: str=0 for the complementary length.
  - Symbol length is always SYM_LONG+SYM_SHORT.
  - Symbols are back to back, no gaps.
- TERM:
  - str=1 for 1 cycle after the last SYM_LO.
  - Next edge: str=0, busy=0, done=1 for one cycle, state=IDLE.
- Total busy cycles = 4+2L+LEAD+L*(SYM_LONG+SYM_SHORT)+1.
- busy:
  - Rises on the edge that accepts start.
  - Falls on the edge done rises.
- start while busy: ignored, no queueing.
- start coincident with done cycle: ignored, because state is not yet IDLE when sampled.
- Async reset mid-operation:
  - Outputs return to reset values immediately.
  - mode dropping mid-config sends the receiver back to its start state, which is the intended abort.
- Counters: bit counter 5 bits (up to 16), run counter 6 bits; no wrap within legal parameters.

Optional Feature:
- Macro SAM_TX_ABORT_EN adds input `abort` (1 bit).
- With the macro, abort=1 while busy:
  - Next edge: str=0, mode=0, busy=0, done=0, state=IDLE.
  - Mid-config, the receiver returns to start. In normal phase, no terminator is sent, so the receiver never asserts valid.
  - abort in IDLE has no effect.
  - abort has priority over start in the same cycle.
- Without the macro: no `abort` port; a transfer can only be stopped by reset.

Test Plan:
- Nominal transfer, defaults:
  - Stimulus: n=2, d_in=16'h000A, capsn_in=16'h0001, msg_in=16'h0006, start pulse.
  - str during mode-high (12 cycles) = 0010 1010 0001.
  - Then 1 low cycle; symbols 0,1,1,0 (0 = 6 high/12 low, 1 = 12 high/6 low); terminator.
  - done 86 cycles after start acceptance.
  - Attached encoder yields msgcd[3:0]=4'hD with valid.
- n=0, msg_in bit0=1, d=0, N=0:
  - mode high 6 cycles; one 18-cycle symbol; done after 26 cycles.
  - Encoder msgcd[0]=1.
- n=4, msg_in=16'hA5C3, d=16'hFFFF, N=0:
  - 36 config cycles; 16 symbols; done after 326 cycles.
  - Encoder msgcd=16'h5A3C.
- n_in=5 with start:
  - err pulses once; mode, str and busy stay 0.
  - A subsequent legal start proceeds normally.
- Reset and start collisions:
  - Assert reset during CFG_D: outputs 0 immediately.
  - After release, start n=1 completes normally.
  - start pulsed while busy is ignored (done count = 1).
- SAM_TX_ABORT_EN:
  - abort during a symbol: next cycle mode=0, str=0, busy=0, no done pulse.
  - Encoder valid never rises.
